// File: rtl/block_multi_read_ram_with_clear_pkg.sv
// Shared types and sizing helpers for the multi-read block RAM with clear sweep.
// Imported by the clear sequencer and the top-level RAM.
package block_multi_read_ram_with_clear_pkg;

    typedef enum logic {
        RAM_READ_FIRST,
        RAM_WRITE_FIRST
    } ram_collision_mode_e;

    typedef enum logic {
        SEQ_CLEAR,
        SEQ_READY
    } seq_state_e;

    function automatic int index_bits(input int entry_num);
        return (entry_num > 1) ? $clog2(entry_num) : 1;
    endfunction

    function automatic int lane_num(input int entry_bits, input int byte_bits);
        return entry_bits / byte_bits;
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// CLEAR/READY sequencer: sweeps INIT_VALUE through every entry, then hands the
// write port to the user path and raises ready.
module ram_clear_sequencer
    import block_multi_read_ram_with_clear_pkg::*;
#(
    parameter int                        ENTRY_NUM      = 64,
    parameter int                        ENTRY_BIT_SIZE = 32,
    parameter int                        LANE_NUM       = 4,
    parameter int                        INDEX_BIT_SIZE = 6,
    parameter logic [ENTRY_BIT_SIZE-1:0] INIT_VALUE     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      we,
    input  logic [INDEX_BIT_SIZE-1:0] wa,
    input  logic [ENTRY_BIT_SIZE-1:0] wv,
    input  logic [LANE_NUM-1:0]       wbe,
    output logic                      mem_we,
    output logic [INDEX_BIT_SIZE-1:0] mem_wa,
    output logic [ENTRY_BIT_SIZE-1:0] mem_wv,
    output logic [LANE_NUM-1:0]       mem_wbe,
    output logic                      ready
);

    localparam logic [INDEX_BIT_SIZE-1:0] LAST_INDEX  = INDEX_BIT_SIZE'(ENTRY_NUM - 1);
    localparam logic [INDEX_BIT_SIZE:0]   ENTRY_NUM_W = (INDEX_BIT_SIZE + 1)'(ENTRY_NUM);

    seq_state_e                state_d, state_q;
    logic [INDEX_BIT_SIZE-1:0] count_d, count_q;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wv  = wv;
        mem_wbe = wbe;
        ready   = 1'b0;
        case (state_q)
            SEQ_CLEAR: begin
                mem_we  = 1'b1;
                mem_wa  = count_q;
                mem_wv  = INIT_VALUE;
                mem_wbe = '1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_INDEX) begin
                    state_d = SEQ_READY;
                    count_d = '0;
                end
            end
            default: begin
                ready  = 1'b1;
                mem_we = we && ({1'b0, wa} < ENTRY_NUM_W);
                if (clear) begin
                    state_d = SEQ_CLEAR;
                    count_d = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_CLEAR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_multi_read_ram_with_clear.sv
// Multi-read block RAM: one byte-enabled write port, READ_NUM replicated 1W1R
// arrays, selectable collision mode, optional output register, built-in clear.
module block_multi_read_ram_with_clear
    import block_multi_read_ram_with_clear_pkg::*;
#(
    parameter int                        ENTRY_NUM      = 64,
    parameter int                        ENTRY_BIT_SIZE = 32,
    parameter int                        BYTE_BIT_SIZE  = 8,
    parameter int                        READ_NUM       = 2,
    parameter int                        WRITE_FIRST    = 0,
    parameter int                        OUTPUT_REG     = 0,
    parameter logic [ENTRY_BIT_SIZE-1:0] INIT_VALUE     = '0,
    localparam int INDEX_BIT_SIZE = index_bits(ENTRY_NUM),
    localparam int LANE_NUM       = lane_num(ENTRY_BIT_SIZE, BYTE_BIT_SIZE)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     we,
    input  logic [INDEX_BIT_SIZE-1:0]                wa,
    input  logic [ENTRY_BIT_SIZE-1:0]                wv,
    input  logic [LANE_NUM-1:0]                      wbe,
    input  logic [READ_NUM-1:0]                      re,
    input  logic [READ_NUM-1:0][INDEX_BIT_SIZE-1:0]  ra,
    output logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0]  rv,
    input  logic                                     clear,
    output logic                                     ready
);

    localparam ram_collision_mode_e COLLISION_MODE =
        (WRITE_FIRST != 0) ? RAM_WRITE_FIRST : RAM_READ_FIRST;
    localparam logic [INDEX_BIT_SIZE:0] ENTRY_NUM_W = (INDEX_BIT_SIZE + 1)'(ENTRY_NUM);

    logic                      mem_we;
    logic [INDEX_BIT_SIZE-1:0] mem_wa;
    logic [ENTRY_BIT_SIZE-1:0] mem_wv;
    logic [LANE_NUM-1:0]       mem_wbe;

    ram_clear_sequencer #(
        .ENTRY_NUM     (ENTRY_NUM),
        .ENTRY_BIT_SIZE(ENTRY_BIT_SIZE),
        .LANE_NUM      (LANE_NUM),
        .INDEX_BIT_SIZE(INDEX_BIT_SIZE),
        .INIT_VALUE    (INIT_VALUE)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .we     (we),
        .wa     (wa),
        .wv     (wv),
        .wbe    (wbe),
        .mem_we (mem_we),
        .mem_wa (mem_wa),
        .mem_wv (mem_wv),
        .mem_wbe(mem_wbe),
        .ready  (ready)
    );

    for (genvar p = 0; p < READ_NUM; p++) begin : g_port
        logic [ENTRY_BIT_SIZE-1:0] mem_q [ENTRY_NUM];
        logic [ENTRY_BIT_SIZE-1:0] wr_word;
        logic [ENTRY_BIT_SIZE-1:0] rd_d, rd_q;
        logic                      ra_ok;
        logic [INDEX_BIT_SIZE-1:0] ra_idx;

        // Byte-merged word for the write address; also the WRITE_FIRST bypass value.
        always_comb begin
            wr_word = mem_q[mem_wa];
            for (int l = 0; l < LANE_NUM; l++) begin
                if (mem_wbe[l]) begin
                    wr_word[l*BYTE_BIT_SIZE +: BYTE_BIT_SIZE] = mem_wv[l*BYTE_BIT_SIZE +: BYTE_BIT_SIZE];
                end
            end
        end

        // NOTE: the array has no reset; the clear sweep is what initialises it.
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_q[mem_wa] <= wr_word;
            end
        end

        always_comb begin
            ra_ok  = {1'b0, ra[p]} < ENTRY_NUM_W;
            ra_idx = ra_ok ? ra[p] : '0;
            rd_d   = rd_q;
            if (ready && re[p]) begin
                if (!ra_ok) begin
                    rd_d = INIT_VALUE;
                end else if (COLLISION_MODE == RAM_WRITE_FIRST && mem_we && mem_wa == ra[p]) begin
                    rd_d = wr_word;
                end else begin
                    rd_d = mem_q[ra_idx];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                      vld_d, vld_q;
            logic [ENTRY_BIT_SIZE-1:0] out_d, out_q;

            always_comb begin
                vld_d = ready && re[p];
                out_d = vld_q ? rd_q : out_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    out_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    out_q <= out_d;
                end
            end

            assign rv[p] = out_q;
        end else begin : g_no_out_reg
            assign rv[p] = rd_q;
        end
    end

endmodule

// File: tb/tb_block_multi_read_ram_with_clear.sv
// Directed + random bench for two RAM configurations (READ_FIRST/no output reg and
// WRITE_FIRST/output reg) sharing one stimulus, checked against a behavioural model.
module tb_block_multi_read_ram_with_clear;

    localparam logic [15:0] INIT = 16'hA5A5;
    localparam int          N    = 4;

    logic            clk;
    logic            rst;
    logic            we;
    logic [1:0]      wa;
    logic [15:0]     wv;
    logic [1:0]      wbe;
    logic [1:0]      re;
    logic [1:0][1:0] ra;
    logic            clear;
    logic [1:0][15:0] rv_a, rv_b;
    logic            ready_a, ready_b;

    int total = 0;
    int bad   = 0;

    // Behavioural model: memory contents, remaining sweep cycles, per-config read views.
    logic [15:0] m_mem [N];
    int          m_clr;
    logic [15:0] m_rv0 [2];
    logic [15:0] m_s1  [2];
    logic [15:0] m_rv1 [2];
    bit          m_v   [2];

    block_multi_read_ram_with_clear #(
        .ENTRY_NUM(N), .ENTRY_BIT_SIZE(16), .BYTE_BIT_SIZE(8), .READ_NUM(2),
        .WRITE_FIRST(0), .OUTPUT_REG(0), .INIT_VALUE(INIT)
    ) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wv(wv), .wbe(wbe),
        .re(re), .ra(ra), .rv(rv_a), .clear(clear), .ready(ready_a)
    );

    block_multi_read_ram_with_clear #(
        .ENTRY_NUM(N), .ENTRY_BIT_SIZE(16), .BYTE_BIT_SIZE(8), .READ_NUM(2),
        .WRITE_FIRST(1), .OUTPUT_REG(1), .INIT_VALUE(INIT)
    ) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wv(wv), .wbe(wbe),
        .re(re), .ra(ra), .rv(rv_b), .clear(clear), .ready(ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clr = N;
        for (int i = 0; i < N; i++) m_mem[i] = INIT;
        for (int p = 0; p < 2; p++) begin
            m_rv0[p] = '0;
            m_s1[p]  = '0;
            m_rv1[p] = '0;
            m_v[p]   = 1'b0;
        end
    endtask

    // Applies the current inputs to the model as one clock edge.
    task automatic model_edge();
        bit          rdy;
        logic [15:0] merged;
        rdy    = (m_clr == 0);
        merged = m_mem[wa];
        for (int l = 0; l < 2; l++) if (wbe[l]) merged[l*8 +: 8] = wv[l*8 +: 8];
        for (int p = 0; p < 2; p++) begin
            bit          iss;
            logic [15:0] old_v;
            logic [15:0] new_v;
            iss   = rdy && re[p];
            old_v = m_mem[ra[p]];
            new_v = (we && wa == ra[p]) ? merged : old_v;
            if (m_v[p]) m_rv1[p] = m_s1[p];
            if (iss) begin
                m_rv0[p] = old_v;
                m_s1[p]  = new_v;
            end
            m_v[p] = iss;
        end
        if (rdy) begin
            if (we) m_mem[wa] = merged;
            if (clear) begin
                for (int i = 0; i < N; i++) m_mem[i] = INIT;
                m_clr = N;
            end
        end else begin
            m_clr--;
        end
    endtask

    task automatic compare();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rf_rv%0d", p), rv_a[p], m_rv0[p]);
            check($sformatf("wf_rv%0d", p), rv_b[p], m_rv1[p]);
        end
        check("rf_ready", {15'd0, ready_a}, {15'd0, m_clr == 0});
        check("wf_ready", {15'd0, ready_b}, {15'd0, m_clr == 0});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [15:0] v,
                         input logic [1:0] be, input logic [1:0] r,
                         input logic [1:0] a1, input logic [1:0] a0, input logic c);
        we = w; wa = a; wv = v; wbe = be; re = r; ra[1] = a1; ra[0] = a0; clear = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 2'b11, 2'b11, 2'd3, 2'd0, 0);
        model_reset();
        #2;
        check("reset_rv_a0", rv_a[0], 16'h0000);
        check("reset_rv_b1", rv_b[1], 16'h0000);
        check("reset_ready", {15'd0, ready_a}, 16'h0000);
        #10 rst = 1'b0;

        // 1. sweep after reset; ready exactly 4 edges later
        step(); step(); step();
        check("ready_before_sweep_end", {15'd0, ready_a}, 16'h0000);
        step();
        check("ready_after_sweep", {15'd0, ready_b}, 16'h0001);
        step();
        check("first_read_p0", rv_a[0], INIT);
        check("first_read_p1", rv_a[1], INIT);
        step();

        // 2. READ_FIRST collision
        drive(1, 1, 16'h1234, 2'b11, 2'b00, 2'd0, 2'd0, 0); step();
        drive(1, 1, 16'hBEEF, 2'b11, 2'b01, 2'd0, 2'd1, 0); step();
        check("rf_collision_old", rv_a[0], 16'h1234);
        drive(0, 1, 16'h0000, 2'b11, 2'b01, 2'd0, 2'd1, 0); step();
        check("rf_after_write", rv_a[0], 16'hBEEF);
        check("wf_collision_new", rv_b[0], 16'hBEEF);

        // 3. byte enables
        drive(1, 2, 16'h1111, 2'b11, 2'b00, 2'd0, 2'd0, 0); step();
        drive(1, 2, 16'hFF00, 2'b10, 2'b00, 2'd0, 2'd0, 0); step();
        drive(1, 2, 16'h0000, 2'b00, 2'b00, 2'd0, 2'd0, 0); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b01, 2'd0, 2'd2, 0); step();
        check("byte_merge_rf", rv_a[0], 16'hFF11);
        drive(0, 0, 16'h0000, 2'b11, 2'b00, 2'd0, 2'd2, 0); step();
        check("byte_merge_wf", rv_b[0], 16'hFF11);

        // 4. WRITE_FIRST with output register
        drive(1, 3, 16'h00C3, 2'b11, 2'b10, 2'd3, 2'd0, 0); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b00, 2'd3, 2'd0, 0); step();
        check("wf_two_edges", rv_b[1], 16'h00C3);
        step();
        check("wf_hold", rv_b[1], 16'h00C3);

        // 5. clear in READY, writes dropped, second clear ignored
        drive(1, 0, 16'h7777, 2'b11, 2'b00, 2'd0, 2'd0, 0); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b00, 2'd0, 2'd0, 1); step();
        check("clear_drops_ready", {15'd0, ready_a}, 16'h0000);
        drive(1, 0, 16'h1357, 2'b11, 2'b11, 2'd0, 2'd0, 0); step();
        drive(1, 0, 16'h1357, 2'b11, 2'b00, 2'd0, 2'd0, 1); step();
        drive(1, 0, 16'h1357, 2'b11, 2'b00, 2'd0, 2'd0, 0); step();
        check("ready_low_cycle4", {15'd0, ready_a}, 16'h0000);
        step();
        check("ready_back", {15'd0, ready_a}, 16'h0001);
        drive(0, 0, 16'h0000, 2'b11, 2'b01, 2'd0, 2'd0, 0); step();
        check("cleared_entry0", rv_a[0], INIT);

        // 6. async reset mid-sweep and mid-read
        drive(1, 1, 16'h4242, 2'b11, 2'b00, 2'd0, 2'd0, 0); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b11, 2'd1, 2'd1, 0); step(); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b11, 2'd1, 2'd1, 1); step();
        drive(0, 0, 16'h0000, 2'b11, 2'b11, 2'd1, 2'd1, 0); step(); step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_rv_a0", rv_a[0], 16'h0000);
        check("async_rst_rv_b1", rv_b[1], 16'h0000);
        check("async_rst_ready", {15'd0, ready_b}, 16'h0000);
        #2 rst = 1'b0;
        step(); step(); step(); step();
        check("ready_after_rst", {15'd0, ready_a}, 16'h0001);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom), ($urandom_range(0, 39) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
